debug_trace_buffer: RTL and testbench



---
 rtl/debug_trace_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_debug_trace_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
// Watches the processor debug bus and records one 28-bit trace entry
// {State, PC, A, B} whenever the program counter moves. Entries are held
// in a DEPTH-deep FIFO. They are streamed out as four bytes per entry over
// a valid/ready handshake, with out_last marking the final byte.
module debug_trace_buffer #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          clear_ovf,
  input  logic [7:0]    debug_A,
  input  logic [7:0]    debug_B,
  input  logic [7:0]    debug_PC,
  input  logic [3:0]    debug_State,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } ser_state_t;

  ser_state_t    state_q, state_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    prevPc_q, prevPc_d;
  logic          armed_q, armed_d;
  logic          overflow_q, overflow_d;
  logic [27:0]   mem_q [DEPTH];

  logic          captureReq;
  logic          popEntry;
  logic          pushEntry;
  logic          dropEntry;
  logic [27:0]   newEntry;
  logic [27:0]   headEntry;

  assign newEntry  = {debug_State, debug_PC, debug_A, debug_B};
  assign headEntry = mem_q[rdPtr_q];

  // Decide this edge's capture, pop, push and drop.
  // A pop that completes on the same edge frees a slot, so a full FIFO
  // can still accept an entry.
  always_comb begin
    captureReq = capture_en && (armed_q || (debug_PC != prevPc_q));
    popEntry   = (state_q == B3) && out_ready;
    pushEntry  = captureReq && ((count_q < DEPTH_C) || popEntry);
    dropEntry  = captureReq && !pushEntry;
  end

  // Compute the next values of the pointers, the occupancy, the PC tracker and the overflow flag.
  // On a drop, setting overflow takes priority over clear_ovf.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    prevPc_d   = prevPc_q;
    armed_d    = armed_q;
    overflow_d = overflow_q;

    if (pushEntry) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popEntry) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({pushEntry, popEntry})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (capture_en) begin
      prevPc_d = debug_PC;
    end
    if (captureReq) begin
      armed_d = 1'b0;
    end

    if (dropEntry) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Register the FIFO bookkeeping, the PC tracker and the flags.
  // A reset discards every stored entry by zeroing the pointers and the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      prevPc_q   <= 8'h00;
      armed_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      prevPc_q   <= prevPc_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
    end
  end

  // Write the entry storage.
  // Only the write-pointer slot changes, so the head entry stays stable while it is serialized.
  always_ff @(posedge clk) begin
    if (pushEntry) begin
      mem_q[wrPtr_q] <= newEntry;
    end
  end

  // Register the serializer state.
  // A reset returns it to IDLE and drops any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Compute the serializer's next state.
  // Each byte advances only on a handshake. After B3 it always passes through IDLE,
  // which leaves a one-cycle gap between entries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = B0;
        end
      end
      B0: begin
        if (out_ready) begin
          state_d = B1;
        end
      end
      B1: begin
        if (out_ready) begin
          state_d = B2;
        end
      end
      B2: begin
        if (out_ready) begin
          state_d = B3;
        end
      end
      B3: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive the byte stream from the head entry.
  // The output depends only on the registered state and the head slot, so it stays stable while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      B0: begin
        out_valid = 1'b1;
        out_data  = {4'hA, headEntry[27:24]};
      end
      B1: begin
        out_valid = 1'b1;
        out_data  = headEntry[23:16];
      end
      B2: begin
        out_valid = 1'b1;
        out_data  = headEntry[15:8];
      end
      B3: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = headEntry[7:0];
      end
      default: begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Testbench for debug_trace_buffer.
// A fixed vector table covers a single entry with backpressure.
// Hand-written sequences cover overflow, full-with-pop and reset mid-stream.
// A randomized run is then checked against a queue-based reference model.
module tb_debug_trace_buffer;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          captureEn;
   logic          clearOvf;
   logic [7:0]    debugA;
   logic [7:0]    debugB;
   logic [7:0]    debugPC;
   logic [3:0]    debugState;
   logic [7:0]    outData;
   logic          outValid;
   logic          outReady;
   logic          outLast;
   logic [CW-1:0] countO;
   logic          fullO;
   logic          emptyO;
   logic          overflowO;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model state: a queue of stored entries, the beat position
   // within the entry being sent (0 = nothing on the bus, 1..4 = byte number),
   // the last PC seen and the sticky flags.
   logic [27:0] mq[$];
   int          mBeat;
   logic [7:0]  mPrev;
   logic        mArmed;
   logic        mOvf;

   typedef struct {
      logic       cen;
      logic [7:0] pc;
      logic       ready;
      logic       expValid;
      logic [7:0] expData;
      logic       expLast;
      int         expCount;
   } vec_t;

   vec_t tbl[10];

   debug_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .capture_en (captureEn),
      .clear_ovf  (clearOvf),
      .debug_A    (debugA),
      .debug_B    (debugB),
      .debug_PC   (debugPC),
      .debug_State(debugState),
      .out_data   (outData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_last   (outLast),
      .count      (countO),
      .full       (fullO),
      .empty      (emptyO),
      .overflow   (overflowO)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic cen, input logic clr,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] pc, input logic [3:0] st,
                                input logic ready);
      rst        = r;
      captureEn  = cen;
      clearOvf   = clr;
      debugA     = a;
      debugB     = b;
      debugPC    = pc;
      debugState = st;
      outReady   = ready;
   endtask

   // Advance the model by one clock edge from the values present at that edge.
   task automatic modelEdge();
      bit pop;
      bit cap;
      bit accept;
      if (rst) begin
         mq.delete();
         mBeat  = 0;
         mPrev  = 8'h00;
         mArmed = 1'b1;
         mOvf   = 1'b0;
         return;
      end
      pop    = (mBeat == 4) && outReady;
      cap    = captureEn && (mArmed || debugPC != mPrev);
      accept = cap && (mq.size() < DEPTH || pop);
      if (mBeat == 0) begin
         if (mq.size() > 0) mBeat = 1;
      end else if (outReady) begin
         mBeat = (mBeat == 4) ? 0 : mBeat + 1;
      end
      if (cap && !accept) mOvf = 1'b1;
      else if (clearOvf)  mOvf = 1'b0;
      if (pop)    void'(mq.pop_front());
      if (accept) mq.push_back({debugState, debugPC, debugA, debugB});
      if (captureEn) mPrev = debugPC;
      if (cap) mArmed = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [27:0] h;
      logic [7:0]  eb;
      bit          ev;
      ev = (mBeat != 0);
      cmp({tag, ".valid"}, outValid, ev);
      if (ev) begin
         h = mq[0];
         case (mBeat)
            1:       eb = {4'hA, h[27:24]};
            2:       eb = h[23:16];
            3:       eb = h[15:8];
            default: eb = h[7:0];
         endcase
         cmp({tag, ".data"}, outData, eb);
         cmp({tag, ".last"}, outLast, mBeat == 4);
      end else begin
         cmp({tag, ".last"}, outLast, 0);
      end
      cmp({tag, ".count"}, countO, mq.size());
      cmp({tag, ".full"}, fullO, mq.size() == DEPTH);
      cmp({tag, ".empty"}, emptyO, mq.size() == 0);
      cmp({tag, ".overflow"}, overflowO, mOvf);
   endtask

   initial begin
      int  hs;
      bit  done;
      bit  hiReady;

      // Single-entry table: A=0x12, B=0x34, State=0x2, PC=0x05 held
      tbl[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1};
      tbl[1] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'hA2, 1'b0, 1};
      tbl[2] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0, 1};
      tbl[3] = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0, 1};
      tbl[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0, 1};
      tbl[5] = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b0, 1};
      tbl[6] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h12, 1'b0, 1};
      tbl[7] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h34, 1'b1, 1};
      tbl[8] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[9] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 0};

      mBeat = 0; mPrev = 8'h00; mArmed = 1'b1; mOvf = 1'b0;

      // Reset with random inputs
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 4'($urandom), 1'($urandom));
      tick();
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 4'($urandom), 1'($urandom));
      tick();
      cmp("reset.valid", outValid, 0);
      cmp("reset.data", outData, 8'h00);
      cmp("reset.last", outLast, 0);
      cmp("reset.count", countO, 0);
      cmp("reset.empty", emptyO, 1);
      cmp("reset.overflow", overflowO, 0);
      checkOutput("reset");

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom),
                       8'($urandom), 4'($urandom), 1'($urandom));
         tick();
         cmp("idleAfterReset.count", countO, 0);
         checkOutput("idleAfterReset");
      end

      // Single entry, then backpressure while sending the PC byte
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, tbl[i].cen, 1'b0, 8'h12, 8'h34, tbl[i].pc, 4'h2, tbl[i].ready);
         tick();
         cmp($sformatf("vec%0d.valid", i), outValid, tbl[i].expValid);
         if (tbl[i].expValid) cmp($sformatf("vec%0d.data", i), outData, tbl[i].expData);
         cmp($sformatf("vec%0d.last", i), outLast, tbl[i].expLast);
         cmp($sformatf("vec%0d.count", i), countO, tbl[i].expCount);
         checkOutput($sformatf("vec%0d", i));
      end

      // Overflow: 17 distinct PCs with the stream stalled
      for (int p = 0; p <= 16; p++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'(p), 4'($urandom), 1'b0);
         tick();
         checkOutput("ovfFill");
      end
      cmp("ovf.count", countO, 16);
      cmp("ovf.full", fullO, 1);
      cmp("ovf.overflow", overflowO, 1);

      // Drain: the PC bytes must come out as 0x00..0x0F
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
      hs = 0;
      done = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (outValid) begin
            if (hs % 4 == 1) cmp("drainPC", outData, hs / 4);
            hs++;
         end
         if (hs == 64 && !outValid && emptyO) begin
            done = 1'b1;
            break;
         end
         tick();
         checkOutput("drain");
      end
      cmp("drainDone", done, 1);
      cmp("drainBeats", hs, 64);
      cmp("drain.empty", emptyO, 1);

      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
      cmp("clearOvf.overflow", overflowO, 0);
      checkOutput("clearOvf");

      // Full with a pop on the same edge as a new capture
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'(8'h80 + i), 4'($urandom), 1'b0);
         tick();
         checkOutput("fullFill");
      end
      cmp("fullFill.count", countO, 16);
      cmp("fullFill.overflow", overflowO, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
         tick();
         checkOutput("toLast");
      end
      cmp("toLast.last", outLast, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A, 8'hC3, 8'hF0, 4'h7, 1'b1);
      tick();
      cmp("fullPop.count", countO, 16);
      cmp("fullPop.full", fullO, 1);
      cmp("fullPop.overflow", overflowO, 0);
      checkOutput("fullPop");

      // A drop that coincides with clear_ovf leaves overflow set
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hF0, 4'h0, 1'b0);
      tick();
      checkOutput("preDrop");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 8'hF1, 4'h3, 1'b0);
      tick();
      cmp("dropVsClear.overflow", overflowO, 1);
      checkOutput("dropVsClear");

      // Reset during a B2 beat with three entries stored
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
      tick();
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 8'(8'h40 + i), 8'(i), 4'(i), 1'b0);
         tick();
         checkOutput("midFill");
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 4'h0, 1'b1);
         tick();
         checkOutput("toB2");
      end
      cmp("toB2.data", outData, 8'h21);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03, 4'h0, 1'b1);
      tick();
      cmp("midReset.valid", outValid, 0);
      cmp("midReset.count", countO, 0);
      cmp("midReset.empty", emptyO, 1);
      checkOutput("midReset");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h99, 8'h88, 8'h00, 4'h1, 1'b0);
      tick();
      cmp("armedCapture.count", countO, 1);
      checkOutput("armedCapture");

      // Randomized run against the reference model
      hiReady = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) hiReady = ($urandom_range(0, 1) == 1);
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 29) == 0,
                       8'($urandom), 8'($urandom),
                       8'($urandom_range(0, 7)), 4'($urandom),
                       hiReady ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 5) == 0));
         tick();
         checkOutput("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
